// File: rtl/rs_encoder_if.sv
// Valid/ready bus between a data-word producer, the RS(7,5) encoder and the
// codeword consumer. The producer/consumer side is the master and the encoder
// is the slave.
interface rs_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_codeword;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_codeword
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_codeword
  );
endinterface

// File: rtl/rs_encoder.sv
// Systematic RS(7,5) encoder over GF(8), with symbols in index form
// (0 = zero, k = alpha^(k-1)).
// Five data symbols are fed, c6 first, through a 2-stage LFSR that divides by
// g(x) = x^2 + a^4 x + a^3. That takes one symbol per cycle. The codeword is
// {data, c1, c0}.
// Optional build macro RS_ENC_ERR_INJECT_EN adds err_en/err_pos/err_val.
// These inputs corrupt one symbol of the finished codeword so that the
// downstream decoder can be exercised.
module rs_encoder (
  input  logic       clk,
  input  logic       reset,
`ifdef RS_ENC_ERR_INJECT_EN
  input  logic       err_en,
  input  logic [2:0] err_pos,
  input  logic [2:0] err_val,
`endif
  rs_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENCODE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [14:0] r_data;
  logic [2:0]  r_r1;
  logic [2:0]  r_r0;
  logic [2:0]  r_cnt;
  logic [20:0] r_codeword;

  logic        w_accept;
  logic        w_last;
  logic [2:0]  w_sym;
  logic [2:0]  w_f;
  logic [2:0]  w_r1_next;
  logic [2:0]  w_r0_next;
  logic [20:0] w_clean;
  logic [20:0] w_final;

  // Index form to polynomial form. Bit 2 holds the alpha^0 coefficient.
  function automatic logic [2:0] idx_to_poly(input logic [2:0] idx);
    case (idx)
      3'd1:    return 3'b100;
      3'd2:    return 3'b010;
      3'd3:    return 3'b001;
      3'd4:    return 3'b110;
      3'd5:    return 3'b011;
      3'd6:    return 3'b111;
      3'd7:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // Polynomial form back to index form.
  function automatic logic [2:0] poly_to_idx(input logic [2:0] poly);
    case (poly)
      3'b100:  return 3'd1;
      3'b010:  return 3'd2;
      3'b001:  return 3'd3;
      3'b110:  return 3'd4;
      3'b011:  return 3'd5;
      3'b111:  return 3'd6;
      3'b101:  return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // GF(8) addition of two index-form symbols.
  function automatic logic [2:0] gf_add(input logic [2:0] a, input logic [2:0] b);
    return poly_to_idx(idx_to_poly(a) ^ idx_to_poly(b));
  endfunction

  // Multiply an index-form symbol by the constant alpha^j (j in 0..6).
  function automatic logic [2:0] gf_mul_alpha(input logic [2:0] k, input logic [2:0] j);
    logic [3:0] s;
    if (k == 3'd0) return 3'd0;
    s = {1'b0, k} + {1'b0, j} - 4'd1;
    if (s >= 4'd7) s = s - 4'd7;
    return s[2:0] + 3'd1;
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_last   = (r_state == S_ENCODE) && (r_cnt == 3'd4);

  // State register. Reset returns to IDLE and discards any word in flight.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic for IDLE -> ENCODE (5 cycles) -> DONE -> IDLE.
  // NOTE: default assignment first keeps this comb block latch-free.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_valid)  w_state_next = S_ENCODE;
      S_ENCODE: if (r_cnt == 3'd4) w_state_next = S_DONE;
      S_DONE:   if (bus.out_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
  end

  assign bus.out_codeword = r_codeword;

  // Select the data symbol for this ENCODE cycle, highest degree first.
  always_comb begin
    case (r_cnt)
      3'd0:    w_sym = r_data[14:12];
      3'd1:    w_sym = r_data[11:9];
      3'd2:    w_sym = r_data[8:6];
      3'd3:    w_sym = r_data[5:3];
      3'd4:    w_sym = r_data[2:0];
      default: w_sym = 3'd0;
    endcase
  end

  // One LFSR division step. The feedback f multiplies the generator taps.
  always_comb begin
    w_f       = gf_add(w_sym, r_r1);
    w_r1_next = gf_add(r_r0, gf_mul_alpha(w_f, 3'd4));
    w_r0_next = gf_mul_alpha(w_f, 3'd3);
    w_clean   = {r_data, w_r1_next, w_r0_next};
  end

`ifdef RS_ENC_ERR_INJECT_EN
  // Optional single-symbol corruption, applied after parity is formed.
  // Position 7 does not exist and is ignored.
  always_comb begin
    w_final = w_clean;
    if (err_en) begin
      for (int p = 0; p < 7; p++) begin
        if (err_pos == 3'(p)) w_final[3*p +: 3] = gf_add(w_clean[3*p +: 3], err_val);
      end
    end
  end
`else
  // Clean build: the codeword goes out exactly as encoded.
  always_comb begin
    w_final = w_clean;
  end
`endif

  // Datapath: latch the word on accept and step the LFSR during ENCODE.
  // Publish the codeword on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= '0;
      r_r1       <= '0;
      r_r0       <= '0;
      r_cnt      <= '0;
      r_codeword <= '0;
    end else if (w_accept) begin
      r_data <= bus.in_data;
      r_r1   <= '0;
      r_r0   <= '0;
      r_cnt  <= '0;
    end else if (r_state == S_ENCODE) begin
      r_r1  <= w_r1_next;
      r_r0  <= w_r0_next;
      r_cnt <= r_cnt + 3'd1;
      if (w_last) r_codeword <= w_final;
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder.
// The driver pushes the expected codeword into a scoreboard queue when a word
// is accepted. The monitor compares that entry against out_codeword on every
// cycle that out_valid is high, and pops it when out_ready completes the
// transfer. Expected codewords come from directed constants or from a
// polynomial long-division model of the encoder.
module tb_rs_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rs_encoder_if bus();

`ifdef RS_ENC_ERR_INJECT_EN
  logic       err_en;
  logic [2:0] err_pos;
  logic [2:0] err_val;
`endif

  rs_encoder dut (
    .clk     (clk),
    .reset   (reset),
`ifdef RS_ENC_ERR_INJECT_EN
    .err_en  (err_en),
    .err_pos (err_pos),
    .err_val (err_val),
`endif
    .bus     (bus)
  );

  typedef struct {
    logic [20:0] exp;
    int          acc_cyc;
  } item_t;

  item_t sb_q[$];

  int n_vec      = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int rdy_mode   = 1;   // 0 = random, 1 = always high, 2 = held low
  bit first_seen = 1'b0;
  bit resume_chk = 1'b0;

  logic       tx_en;
  logic [2:0] tx_pos;
  logic [2:0] tx_val;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready changes only just after the rising edge.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.out_ready = ($urandom_range(0, 3) != 0);
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Index form to polynomial form. Bit 2 holds the alpha^0 coefficient.
  logic [2:0] i2p [8] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b111, 3'b101};

  function automatic logic [2:0] m_add(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] p;
    p = i2p[a] ^ i2p[b];
    for (int k = 0; k < 8; k++) if (i2p[k] == p) return 3'(k);
    return 3'd0;
  endfunction

  function automatic logic [2:0] m_mul(input logic [2:0] a, input logic [2:0] b);
    if (a == 3'd0 || b == 3'd0) return 3'd0;
    return 3'((((int'(a) - 1) + (int'(b) - 1)) % 7) + 1);
  endfunction

  // Codeword = data*x^2 + (data*x^2 mod g). g = x^2 + a^4 x + a^3, whose
  // coefficients in index form are 1, 5, 4.
  function automatic logic [20:0] ref_encode(input logic [14:0] d, input logic en,
                                             input logic [2:0] pos, input logic [2:0] val);
    logic [2:0]  m [7];
    logic [2:0]  q;
    logic [20:0] cw;
    for (int p = 0; p < 7; p++) m[p] = 3'd0;
    for (int i = 0; i < 5; i++) m[6-i] = d[14-3*i -: 3];
    for (int i = 6; i >= 2; i--) begin
      q      = m[i];
      m[i]   = m_add(m[i], q);
      m[i-1] = m_add(m[i-1], m_mul(q, 3'd5));
      m[i-2] = m_add(m[i-2], m_mul(q, 3'd4));
    end
    cw = {d, m[1], m[0]};
    if (en && pos != 3'd7) cw[3*pos +: 3] = m_add(cw[3*pos +: 3], val);
    return cw;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (resume_chk) begin
      check("idle_resume_in_ready", 32'(bus.in_ready), 32'd1);
      resume_chk = 1'b0;
    end
    if (!reset && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        if (!first_seen) begin
          check("latency", 32'(cyc - sb_q[0].acc_cyc), 32'd5);
          first_seen = 1'b1;
        end
        check("codeword", 32'(bus.out_codeword), 32'(sb_q[0].exp));
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        if (bus.out_ready) begin
          void'(sb_q.pop_front());
          first_seen = 1'b0;
          resume_chk = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0 || bus.out_valid) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Offer one word and queue its expected codeword. Error fields come from
  // tx_*. This task is called and returns at a falling edge.
  task automatic send(input logic [14:0] d, input logic [20:0] exp);
    item_t it;
    wait_ready();
    bus.in_data  = d;
    bus.in_valid = 1'b1;
`ifdef RS_ENC_ERR_INJECT_EN
    err_en  = tx_en;
    err_pos = tx_pos;
    err_val = tx_val;
`endif
    @(negedge clk);
    it.exp     = exp;
    it.acc_cyc = cyc;
    sb_q.push_back(it);
    bus.in_valid = 1'b0;
    check("in_ready_drop", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    logic [14:0] d;
    int          t;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tx_en        = 1'b0;
    tx_pos       = 3'd0;
    tx_val       = 3'd0;
`ifdef RS_ENC_ERR_INJECT_EN
    err_en  = 1'b0;
    err_pos = 3'd0;
    err_val = 3'd0;
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready",  32'(bus.in_ready),     32'd1);
    check("reset_out_valid", 32'(bus.out_valid),    32'd0);
    check("reset_codeword",  32'(bus.out_codeword), 32'd0);
    reset = 1'b0;

    // Directed words with out_ready held high.
    rdy_mode = 1;
    send(15'h0000, 21'h000000);
    send(15'h1000, 21'h04002A);
    send(15'h0001, 21'h00006C);
    drain();

    // Back-pressure: the codeword must be held while out_ready is low, and
    // in_valid must be ignored.
    rdy_mode = 2;
    @(negedge clk);
    send(15'h1000, 21'h04002A);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("hold_reached_done", 32'(bus.out_valid), 32'd1);
    repeat (10) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 15'($urandom);
      @(negedge clk);
      check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    rdy_mode = 1;
    send(15'h0001, 21'h00006C);
    drain();

    // Reset in the third ENCODE cycle, with in_valid asserted alongside it.
    send(15'h1000, 21'h04002A);
    @(negedge clk);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 15'h7FFF;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    sb_q.delete();
    first_seen = 1'b0;
    check("midreset_out_valid", 32'(bus.out_valid),    32'd0);
    check("midreset_codeword",  32'(bus.out_codeword), 32'd0);
    check("midreset_in_ready",  32'(bus.in_ready),     32'd1);
    send(15'h0001, 21'h00006C);

`ifdef RS_ENC_ERR_INJECT_EN
    tx_en  = 1'b1;
    tx_pos = 3'd3;
    tx_val = 3'd1;
    send(15'h0000, 21'h000200);
    tx_en  = 1'b0;
`endif
    drain();

    // Randomized words with random back-pressure.
    rdy_mode = 0;
    repeat (60) begin
      d = 15'($urandom);
`ifdef RS_ENC_ERR_INJECT_EN
      tx_en = 1'($urandom_range(0, 1));
`else
      tx_en = 1'b0;
`endif
      tx_pos = 3'($urandom_range(0, 7));
      tx_val = 3'($urandom_range(0, 7));
      send(d, ref_encode(d, tx_en, tx_pos, tx_val));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
